// File: rtl/cp0_state_unit_pkg.sv
// Shared CP0 definitions: register numbers, STATUS/CAUSE bit positions,
// write masks, ExcCode values and the EXL state type.
package cp0_state_unit_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // STATUS bit positions
    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;

    // CAUSE bit positions
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_HW_LO  = 10;
    localparam int unsigned CAUSE_HW_HI  = 15;
    localparam int unsigned CAUSE_IP7    = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

    // Software-writable bits per register
    localparam logic [31:0] MASK_FULL  = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_CAUSE = 32'h0000_0300;
    localparam logic [31:0] MASK_NONE  = 32'h0000_0000;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    typedef enum logic [0:0] {
        StUser,
        StKernelExc
    } cp0_state_e;

    // Writable-bit mask for a CP0 register number; unknown registers ignore writes.
    function automatic logic [31:0] wr_mask(input logic [4:0] addr);
        logic [31:0] m;
        case (addr)
            CP0_STATUS:  m = MASK_FULL;
            CP0_CAUSE:   m = MASK_CAUSE;
            CP0_EPC:     m = MASK_FULL;
            CP0_COMPARE: m = MASK_FULL;
            CP0_COUNT:   m = MASK_FULL;
            default:     m = MASK_NONE;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] merge_masked(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_fwd_mux.sv
// Priority forward selector for one CP0 register number. The youngest
// matching in-flight write (lowest index) wins and is merged over the
// current register value through that register's write mask.
module cp0_fwd_mux
    import cp0_state_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_FWD    = 2
) (
    input  logic [4:0]                    addr,
    input  logic [DATA_WIDTH-1:0]         cur,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [5*NUM_FWD-1:0]          fwd_addr,
    input  logic [DATA_WIDTH*NUM_FWD-1:0] fwd_data,
    output logic [DATA_WIDTH-1:0]         value
);

    logic [DATA_WIDTH-1:0] mask;

    assign mask = wr_mask(addr);

    // Walk oldest to youngest so the lowest matching index is applied last.
    always_comb begin
        value = cur;
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[5*i +: 5] == addr)) begin
                value = merge_masked(cur, fwd_data[DATA_WIDTH*i +: DATA_WIDTH], mask);
            end
        end
    end

endmodule

// File: rtl/cp0_state_unit.sv
// CP0 state block: STATUS, CAUSE, EPC, COUNT, COMPARE with write forwarding,
// exception/ERET commit and a registered interrupt request.
// Build option: define CP0_TIMER_EN to enable the COUNT divider and the
// COUNT==COMPARE timer interrupt; otherwise TI/IP7 follow hw_int[5].
module cp0_state_unit
    import cp0_state_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [4:0]                    wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [5*NUM_FWD-1:0]          fwd_addr,
    input  logic [DATA_WIDTH*NUM_FWD-1:0] fwd_data,
    input  logic [4:0]                    rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [DATA_WIDTH-1:0]         status_fwd,
    output logic [DATA_WIDTH-1:0]         cause_fwd,
    output logic [DATA_WIDTH-1:0]         epc_fwd,
    input  logic                          exc_valid,
    input  logic [4:0]                    exc_code,
    input  logic [DATA_WIDTH-1:0]         exc_pc,
    input  logic                          exc_bd,
    input  logic                          eret,
    input  logic [5:0]                    hw_int,
    output logic                          irq_pending,
    output logic                          exl
);

    cp0_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d, cause_base;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic                  count_wr, compare_wr;
    logic                  timer_bit;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] rd_cur;

    // Commit next-state: exception beats ERET beats MTC0; the EXL FSM owns STATUS.EXL.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        cause_base = cause_q;
        epc_d      = epc_q;
        compare_d  = compare_q;
        count_wr   = 1'b0;
        compare_wr = 1'b0;
        // hw lines own IP[15:10] every cycle, even when CAUSE is written
        cause_base[CAUSE_HW_HI:CAUSE_HW_LO] = hw_int;
        if (exc_valid) begin
            cause_base[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
            if (state_q == StUser) begin
                epc_d                = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                cause_base[CAUSE_BD] = exc_bd;
                state_d              = StKernelExc;
            end
        end else if (eret) begin
            if (state_q == StKernelExc) begin
                state_d = StUser;
            end
        end else if (wr_en) begin
            case (wr_addr)
                CP0_STATUS: begin
                    status_d = wr_data;
                    state_d  = wr_data[STATUS_EXL] ? StKernelExc : StUser;
                end
                CP0_CAUSE:   cause_base = merge_masked(cause_base, wr_data, MASK_CAUSE);
                CP0_EPC:     epc_d = wr_data;
                CP0_COMPARE: begin
                    compare_d  = wr_data;
                    compare_wr = 1'b1;
                end
                CP0_COUNT:   count_wr = 1'b1;
                default:     ;
            endcase
        end
        status_d[STATUS_EXL] = (state_d == StKernelExc);
    end

`ifdef CP0_TIMER_EN
    logic [31:0] div_q, div_d;
    logic        tick;
    logic        flag_q, flag_d;

    // Divider, COUNT increment (COUNT write wins) and COUNT==COMPARE flag.
    always_comb begin
        tick    = (div_q == COUNT_DIV - 1);
        div_d   = tick ? 32'd0 : (div_q + 32'd1);
        count_d = count_q;
        if (count_wr) begin
            count_d = wr_data;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end
        flag_d = flag_q;
        if (compare_wr) begin
            flag_d = 1'b0;
        end else if ((tick || count_wr) && (count_d == compare_d)) begin
            flag_d = 1'b1;
        end
    end

    assign timer_bit = flag_d;

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            flag_q <= flag_d;
        end
    end
`else
    logic unused_count_div;

    assign unused_count_div = (COUNT_DIV == 0);
    assign count_d          = count_wr ? wr_data : count_q;
    assign timer_bit        = hw_int[5];
`endif

    // Fold the timer source into TI and IP7.
    always_comb begin
        cause_d            = cause_base;
        cause_d[CAUSE_TI]  = timer_bit;
        cause_d[CAUSE_IP7] = hw_int[5] | timer_bit;
    end

    // Interrupt request from the registered STATUS/CAUSE values.
    always_comb begin
        irq_d = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                (|(status_q[STATUS_IM_HI:STATUS_IM_LO] & cause_q[CAUSE_IP_HI:CAUSE_IP_LO]));
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StUser;
            status_q  <= '0;
            cause_q   <= '0;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            irq_q     <= irq_d;
        end
    end

    // Registered value for the MFC0 address; unknown registers read as zero.
    always_comb begin
        case (rd_addr)
            CP0_COUNT:   rd_cur = count_q;
            CP0_COMPARE: rd_cur = compare_q;
            CP0_STATUS:  rd_cur = status_q;
            CP0_CAUSE:   rd_cur = cause_q;
            CP0_EPC:     rd_cur = epc_q;
            default:     rd_cur = '0;
        endcase
    end

    cp0_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .NUM_FWD(NUM_FWD)) u_fwd_rd (
        .addr      (rd_addr),
        .cur       (rd_cur),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .value     (rd_data)
    );

    cp0_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .NUM_FWD(NUM_FWD)) u_fwd_status (
        .addr      (CP0_STATUS),
        .cur       (status_q),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .value     (status_fwd)
    );

    cp0_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .NUM_FWD(NUM_FWD)) u_fwd_cause (
        .addr      (CP0_CAUSE),
        .cur       (cause_q),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .value     (cause_fwd)
    );

    cp0_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .NUM_FWD(NUM_FWD)) u_fwd_epc (
        .addr      (CP0_EPC),
        .cur       (epc_q),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .value     (epc_fwd)
    );

    assign irq_pending = irq_q;
    assign exl         = status_q[STATUS_EXL];

endmodule

// File: tb/tb_cp0_state_unit.sv
// Scoreboard bench for cp0_state_unit: stimulus pushes expected output values
// tagged with the cycle they must appear in; a negedge monitor pops and checks.
module tb_cp0_state_unit;

    localparam int SEL_RD     = 0;
    localparam int SEL_STATUS = 1;
    localparam int SEL_CAUSE  = 2;
    localparam int SEL_EPC    = 3;
    localparam int SEL_IRQ    = 4;
    localparam int SEL_EXL    = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] mask;
        logic [31:0] exp;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data, status_fwd, cause_fwd, epc_fwd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret;
    logic [5:0]  hw_int;
    logic        irq_pending;
    logic        exl;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    cp0_state_unit #(.DATA_WIDTH(32), .NUM_FWD(2), .COUNT_DIV(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .status_fwd  (status_fwd),
        .cause_fwd   (cause_fwd),
        .epc_fwd     (epc_fwd),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .exc_pc      (exc_pc),
        .exc_bd      (exc_bd),
        .eret        (eret),
        .hw_int      (hw_int),
        .irq_pending (irq_pending),
        .exl         (exl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            SEL_RD:     return rd_data;
            SEL_STATUS: return status_fwd;
            SEL_CAUSE:  return cause_fwd;
            SEL_EPC:    return epc_fwd;
            SEL_IRQ:    return {31'b0, irq_pending};
            default:    return {31'b0, exl};
        endcase
    endfunction

    task automatic push_exp(input string name, input int sel, input logic [31:0] mask,
                            input logic [31:0] exp, input int delay);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.mask = mask;
        e.exp  = exp;
        e.cyc  = cyc + delay;
        sb.push_back(e);
    endtask

    // Monitor: check every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [31:0] act;
                act = get_out(sb[i].sel);
                n_tests++;
                if ((act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (mask %h) at cycle %0d",
                             sb[i].name, act & sb[i].mask, sb[i].exp & sb[i].mask,
                             sb[i].mask, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        // Reset with garbage on every input.
        rst_n     = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 5'd12;
        wr_data   = 32'hFFFF_FFFF;
        fwd_valid = 2'b11;
        fwd_addr  = 10'h3FF;
        fwd_data  = '1;
        rd_addr   = 5'd12;
        exc_valid = 1'b1;
        exc_code  = 5'h1F;
        exc_pc    = 32'hFFFF_FFFF;
        exc_bd    = 1'b1;
        eret      = 1'b1;
        hw_int    = 6'h3F;
        repeat (3) step();
        wr_en = 1'b0; fwd_valid = 2'b00; fwd_addr = '0; fwd_data = '0;
        exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
        eret = 1'b0; hw_int = '0;
        push_exp("reset_rd",     SEL_RD,     32'hFFFF_FFFF, 32'h0, 0);
        push_exp("reset_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0, 0);
        push_exp("reset_cause",  SEL_CAUSE,  32'hFFFF_FFFF, 32'h0, 0);
        push_exp("reset_epc",    SEL_EPC,    32'hFFFF_FFFF, 32'h0, 0);
        push_exp("reset_irq",    SEL_IRQ,    32'h1,         32'h0, 0);
        push_exp("reset_exl",    SEL_EXL,    32'h1,         32'h0, 0);
        step();
        rst_n = 1'b1;
        step();

        // Forward conflict: youngest stage wins, then fall back to registered value.
        mtc0(5'd12, 32'h0000_FF00);
        fwd_valid = 2'b11;
        fwd_addr  = {5'd12, 5'd12};
        fwd_data  = {32'h22, 32'h11};
        push_exp("fwd_conflict_rd",     SEL_RD,     32'hFFFF_FFFF, 32'h11, 0);
        push_exp("fwd_conflict_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h11, 0);
        step();
        fwd_valid = 2'b10;
        fwd_addr  = {5'd13, 5'd0};
        fwd_data  = {32'hFFFF_FFFF, 32'h0};
        push_exp("fwd_cause_mask", SEL_CAUSE, 32'hFFFF_FFFF, 32'h0000_0300, 0);
        step();
        fwd_valid = 2'b11;
        fwd_addr  = {5'd14, 5'd12};
        fwd_data  = {32'hDEAD_BEEF, 32'h5};
        push_exp("fwd_split_epc",    SEL_EPC,    32'hFFFF_FFFF, 32'hDEAD_BEEF, 0);
        push_exp("fwd_split_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h5, 0);
        step();
        fwd_valid = 2'b00;
        push_exp("fwd_off_rd", SEL_RD, 32'hFFFF_FFFF, 32'h0000_FF00, 0);
        step();

        // Exception in delay slot, nested exception, ERET, ERET in user mode.
        exc_valid = 1'b1; exc_pc = 32'h80; exc_bd = 1'b1; exc_code = 5'h0C;
        step();
        exc_valid = 1'b0;
        rd_addr = 5'd14;
        push_exp("exc_epc",   SEL_EPC,   32'hFFFF_FFFF, 32'h7C, 0);
        push_exp("exc_rd",    SEL_RD,    32'hFFFF_FFFF, 32'h7C, 0);
        push_exp("exc_cause", SEL_CAUSE, 32'h8000_007C, 32'h8000_0030, 0);
        push_exp("exc_exl",   SEL_EXL,   32'h1,         32'h1, 0);
        step();
        exc_valid = 1'b1; exc_pc = 32'h200; exc_bd = 1'b0; exc_code = 5'h04;
        step();
        exc_valid = 1'b0;
        push_exp("nested_epc",   SEL_EPC,   32'hFFFF_FFFF, 32'h7C, 0);
        push_exp("nested_cause", SEL_CAUSE, 32'h8000_007C, 32'h8000_0010, 0);
        push_exp("nested_exl",   SEL_EXL,   32'h1,         32'h1, 0);
        eret = 1'b1;
        step();
        push_exp("eret_exl",    SEL_EXL,    32'h1,         32'h0, 0);
        push_exp("eret_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_FF00, 0);
        step();
        eret = 1'b0;
        push_exp("eret_user_exl", SEL_EXL, 32'h1, 32'h0, 0);
        step();

        // Interrupt request: two cycles after hw_int rises, drops after EXL set.
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        push_exp("irq_lat1", SEL_IRQ, 32'h1, 32'h0, 1);
        push_exp("irq_lat2", SEL_IRQ, 32'h1, 32'h1, 2);
        step();
        step();
        mtc0(5'd12, 32'h0000_0403);
        push_exp("irq_exl_hold", SEL_IRQ, 32'h1, 32'h1, 0);
        push_exp("irq_exl_drop", SEL_IRQ, 32'h1, 32'h0, 1);
        push_exp("mtc0_exl",     SEL_EXL, 32'h1, 32'h1, 0);
        step();

        // Same-cycle exception, ERET and MTC0 STATUS: only the exception commits.
        mtc0(5'd12, 32'h0000_0401);
        push_exp("mtc0_clear_exl", SEL_EXL, 32'h1, 32'h0, 0);
        exc_valid = 1'b1; exc_pc = 32'h300; exc_bd = 1'b0; exc_code = 5'h08;
        eret = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0;
        step();
        exc_valid = 1'b0; eret = 1'b0; wr_en = 1'b0;
        push_exp("prio_exl",    SEL_EXL,    32'h1,         32'h1, 0);
        push_exp("prio_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_0403, 0);
        push_exp("prio_epc",    SEL_EPC,    32'hFFFF_FFFF, 32'h300, 0);
        push_exp("prio_cause",  SEL_CAUSE,  32'h8000_007C, 32'h0000_0020, 0);
        step();

        // CAUSE write touches only IP1:0 while hw lines own IP[15:10].
        hw_int = 6'b000011;
        mtc0(5'd13, 32'hFFFF_FFFF);
        push_exp("cause_wr_mask", SEL_CAUSE, 32'h8000_FF7C, 32'h0000_0F20, 0);
        hw_int = 6'b000000;
        step();

        // Unknown register: writes ignored, reads and forwards give zero.
        fwd_valid = 2'b01;
        fwd_addr  = {5'd0, 5'd3};
        fwd_data  = {32'h0, 32'hFFFF_FFFF};
        rd_addr   = 5'd3;
        mtc0(5'd3, 32'hFFFF_FFFF);
        push_exp("unknown_rd", SEL_RD, 32'hFFFF_FFFF, 32'h0, 0);
        fwd_valid = 2'b00;
        step();

        mtc0(5'd11, 32'h0000_1234);
        rd_addr = 5'd11;
        push_exp("compare_rd", SEL_RD, 32'hFFFF_FFFF, 32'h0000_1234, 0);
        step();

`ifdef CP0_TIMER_EN
        begin
            int k;
            mtc0(5'd11, 32'h5);
            mtc0(5'd9, 32'h0);
            push_exp("timer_ti_clear", SEL_CAUSE, 32'h4000_8000, 32'h0, 0);
            k = 0;
            while (k < 14 && cause_fwd[30] !== 1'b1) begin
                step();
                k++;
            end
            n_tests++;
            if (k < 9 || k > 10) begin
                n_fail++;
                $display("FAIL timer_ti_latency: got %0d cycles expected 9..10", k);
            end
            push_exp("timer_ti_ip7", SEL_CAUSE, 32'h4000_8000, 32'h4000_8000, 0);
            step();
            mtc0(5'd11, 32'h100);
            push_exp("timer_compare_clr", SEL_CAUSE, 32'h4000_8000, 32'h0, 0);
            rd_addr = 5'd9;
            mtc0(5'd9, 32'hFFFF_FFFF);
            push_exp("count_wr",   SEL_RD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
            push_exp("count_wrap", SEL_RD, 32'hFFFF_FFFF, 32'h0, 2);
            step();
            step();
        end
`else
        rd_addr = 5'd9;
        mtc0(5'd9, 32'h0000_ABCD);
        push_exp("count_plain",      SEL_RD, 32'hFFFF_FFFF, 32'h0000_ABCD, 0);
        push_exp("count_plain_hold", SEL_RD, 32'hFFFF_FFFF, 32'h0000_ABCD, 3);
        hw_int = 6'b100000;
        push_exp("hw5_ti_ip7", SEL_CAUSE, 32'h4000_8000, 32'h4000_8000, 1);
        step();
        hw_int = 6'b000000;
        step();
        step();
`endif

        repeat (3) step();
        for (int w = 0; w < 10 && sb.size() != 0; w++) step();
        while (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no check expected check at cycle %0d", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_state_unit.md
Name: cp0_state_unit

Overview:
Parametrised coprocessor-0 state block: holds STATUS, CAUSE, EPC, COUNT and COMPARE.
Forwards in-flight CP0 writes from NUM_FWD pipeline stages to consumers.
Commits exceptions and ERET, and raises the interrupt request to the exception logic.
Sits beside the MEM stage; write-back drives the commit port, and MEM/WB stages drive the forward ports.

Parameters:
DATA_WIDTH, 32, CP0 register width; must be 32 (CAUSE/STATUS bit positions fixed).
NUM_FWD, 2, number of forwarding sources; index 0 is youngest and has highest priority.
COUNT_DIV, 2, COUNT increments once every COUNT_DIV clocks; must be >= 1.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
wr_en  in  1  committed MTC0 write
wr_addr  in  5  CP0 register number of committed write
wr_data  in  DATA_WIDTH  committed write data
fwd_valid  in  NUM_FWD  in-flight CP0 write valid, per stage
fwd_addr  in  5*NUM_FWD  packed register numbers, stage i at [5i+4:5i]
fwd_data  in  DATA_WIDTH*NUM_FWD  packed data
rd_addr  in  5  MFC0 read address
rd_data  out  DATA_WIDTH  forwarded read value (combinational)
status_fwd / cause_fwd / epc_fwd  out  DATA_WIDTH each  forwarded views for the exception handler
exc_valid  in  1  exception commit
exc_code  in  5  ExcCode
exc_pc  in  DATA_WIDTH  faulting PC
exc_bd  in  1  faulting instruction is in a delay slot
eret  in  1  ERET commit
hw_int  in  6  hardware interrupt lines, sampled each clock
irq_pending  out  1  registered interrupt request
exl  out  1  STATUS.EXL, registered

Behaviour:
- Register numbers: COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14. Any other address: writes ignored, reads return 0.
- Reset (rst_n=0 at a clock edge): all registers 0, divider 0, irq_pending=0, exl=0. Outputs combinational from registers, so they read 0 the cycle after reset.
- Write masks:
  - STATUS: fully writable.
  - CAUSE: only [9:8] (IP1:0) writable.
  - EPC, COMPARE, COUNT: fully writable.
- Forwarding (combinational): the value for address A is taken from the lowest index i with fwd_valid[i] && fwd_addr[i]==A.
  - The same write mask is applied, merged over the current register value.
  - If no stage matches, the registered value is used.
  - wr_* is NOT forwarded; it is already registered next cycle.
- CAUSE.IP[15:10] <= hw_int every clock (1-cycle sample latency). CAUSE.IP7 (bit 15) is ORed with the timer flag.
- Commit priority in one cycle: exc_valid > eret > wr_en. A lower-priority event in the same cycle is dropped.
- FSM on STATUS.EXL, two states: USER (EXL=0) and KERNEL_EXC (EXL=1).
  - USER + exc_valid -> KERNEL_EXC:
    - EPC <= exc_bd ? exc_pc-4 : exc_pc
    - CAUSE.BD[31] <= exc_bd
    - CAUSE.ExcCode[6:2] <= exc_code
    - EXL <= 1
  - KERNEL_EXC + exc_valid (nested): ExcCode updated; EPC and BD unchanged; stays in KERNEL_EXC.
  - KERNEL_EXC + eret -> USER: EXL <= 0.
  - eret in USER: no effect.
  - MTC0 to STATUS may change EXL directly; the state follows STATUS.EXL.
- irq_pending registered: next = STATUS.IE[0] & ~EXL & |(STATUS.IM[15:8] & CAUSE.IP[15:8]). Computed from post-update values (1-cycle latency from the register change).
- Simultaneous wr_en to CAUSE and hw_int sample: the write affects only [9:8]; the hw sample owns [15:10]. Both take effect.

Optional Feature:
CP0_TIMER_EN.
- Defined:
  - COUNT increments (wrapping at 2^32) when the divider reaches COUNT_DIV-1.
  - When COUNT==COMPARE after update, the timer flag is set (CAUSE.TI[30] and IP7).
  - A write to COMPARE clears the flag.
  - A write to COUNT overrides the increment that cycle.
- Undefined:
  - COUNT/COMPARE are plain read/write registers.
  - No divider logic; TI and IP7 come from hw_int[5] only.

Decomposition:
- Shared package/defines: CP0 register numbers, STATUS/CAUSE bit indices, write-mask constants, ExcCode values.
- One natural sub-module, cp0_fwd_mux: a priority forward selector for a single address, instantiated four times (rd_addr, STATUS, CAUSE, EPC).

Test Plan:
- Reset with garbage on all inputs for 3 cycles -> every output 0; irq_pending=0.
- Forward conflict: fwd_valid=2'b11, both stages address 12, data 0x11 (idx0) / 0x22 (idx1); rd_addr=12 -> rd_data=0x11. Clear fwd_valid -> registered value.
- Exception with exc_pc=0x80, exc_bd=1, code=0x0C -> next cycle EPC=0x7C, CAUSE[31]=1, CAUSE[6:2]=0x0C, exl=1. A nested exc_valid keeps EPC=0x7C. eret -> exl=0.
- STATUS=0x0000_0401 written, then hw_int[0]=1 -> irq_pending=1 two cycles after hw_int rises. Set EXL -> irq_pending drops the next cycle.
- Same-cycle exc_valid, eret and wr_en to STATUS=0 -> only the exception commits; STATUS.EXL=1.
- CP0_TIMER_EN, COUNT_DIV=2, COMPARE=5, COUNT=0 -> TI=1 ten cycles later. Write COMPARE=0x100 -> TI=0. COUNT=0xFFFF_FFFF wraps to 0.
